// File: rtl/i2c_rx_byte_controller.sv
// I2C master read-byte engine: clocks 8 bits in from the slave MSB-first, then drives ACK/NACK on pulse 9.
// Paced by a quarter-SCL-period tick; honours SCL stretching up to STRETCH_TIMEOUT ticks (0 = no limit).
module i2c_rx_byte_controller #(
  parameter int STRETCH_TIMEOUT = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_rx_start,
  input  logic       i_ack,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_rx_error,
  output logic       o_busy,
  output logic       o_sda,
  output logic       o_scl,
  output logic       o_sda_disable,
  output logic       o_scl_disable
);

  localparam int CNT_W = (STRETCH_TIMEOUT < 2) ? 1 : $clog2(STRETCH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(STRETCH_TIMEOUT);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    BIT1 = 4'd1,
    BIT2 = 4'd2,
    BIT3 = 4'd3,
    BIT4 = 4'd4,
    BIT5 = 4'd5,
    BIT6 = 4'd6,
    BIT7 = 4'd7,
    BIT8 = 4'd8,
    ACK  = 4'd9
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       step, step_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [7:0]       shreg, shreg_nxt;
  logic             ack_q, ack_nxt;
  logic [7:0]       data_nxt;
  logic             valid_nxt, error_nxt, busy_nxt, sda_nxt, scl_nxt;
  logic             in_byte, in_bits;

  assign in_bits = state inside {BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7, BIT8};
  assign in_byte = in_bits || (state == ACK);

  // SCL is only released around the high half of each pulse; the slave owns SDA for the 8 data bits.
  assign o_scl_disable = in_byte && ((step == 2'd1) || (step == 2'd2));
  assign o_sda_disable = in_bits;

  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      step       <= 2'd0;
      cnt        <= '0;
      shreg      <= 8'd0;
      ack_q      <= 1'b0;
      o_rx_data  <= 8'd0;
      o_rx_valid <= 1'b0;
      o_rx_error <= 1'b0;
      o_busy     <= 1'b0;
      o_sda      <= 1'b1;
      o_scl      <= 1'b0;
    end else begin
      state      <= state_nxt;
      step       <= step_nxt;
      cnt        <= cnt_nxt;
      shreg      <= shreg_nxt;
      ack_q      <= ack_nxt;
      o_rx_data  <= data_nxt;
      o_rx_valid <= valid_nxt;
      o_rx_error <= error_nxt;
      o_busy     <= busy_nxt;
      o_sda      <= sda_nxt;
      o_scl      <= scl_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    ack_nxt   = ack_q;
    data_nxt  = o_rx_data;
    valid_nxt = 1'b0;
    error_nxt = 1'b0;
    busy_nxt  = o_busy;
    sda_nxt   = o_sda;
    scl_nxt   = o_scl;

    case (state)
      IDLE: begin
        scl_nxt  = 1'b0;
        sda_nxt  = 1'b1;
        busy_nxt = 1'b0;
        step_nxt = 2'd0;
        // A start coinciding with the completion pulse belongs to the finished byte and is dropped.
        if (i_rx_start && !o_rx_valid) begin
          ack_nxt   = i_ack;
          shreg_nxt = 8'd0;
          state_nxt = BIT1;
          busy_nxt  = 1'b1;
        end
      end

      BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7, BIT8, ACK: begin
        if (i_tick) begin
          case (step)
            2'd0: begin
              scl_nxt  = 1'b1;
              cnt_nxt  = '0;
              step_nxt = 2'd1;
            end
            2'd1: begin
              if (i_scl) begin
                step_nxt = 2'd2;
              end else begin
                cnt_nxt = cnt_inc;
                if ((STRETCH_TIMEOUT != 0) && (cnt_inc == TIMEOUT_C)) begin
                  error_nxt = 1'b1;
                  state_nxt = IDLE;
                  step_nxt  = 2'd0;
                  busy_nxt  = 1'b0;
                  scl_nxt   = 1'b0;
                  sda_nxt   = 1'b1;
                end
              end
            end
            2'd2: begin
              if (state != ACK) shreg_nxt = {shreg[6:0], i_sda};
              scl_nxt  = 1'b0;
              step_nxt = 2'd3;
            end
            default: begin
              step_nxt = 2'd0;
              if (state == ACK) begin
                data_nxt  = shreg;
                valid_nxt = 1'b1;
                sda_nxt   = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
              end else begin
                state_nxt = state_t'(state + 4'd1);
                // Master takes SDA for the acknowledge bit: low = ACK, high = NACK.
                if (state == BIT8) sda_nxt = ~ack_q;
              end
            end
          endcase
        end
      end

      default: begin
        state_nxt = IDLE;
        step_nxt  = 2'd0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
